// File: rtl/prio_enc_pkg.sv
// Shared sizes, FSM state type and the fixed-priority index helper for the
// sequential 4-to-2 priority encoder.
package prio_enc_pkg;
  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

  // Later (higher) indices overwrite earlier ones, so bit 3 wins.
  function automatic logic [CODE_W-1:0] highest_index(input logic [N_REQ-1:0] p);
    highest_index = '0;
    for (int i = 0; i < N_REQ; i++)
      if (p[i]) highest_index = CODE_W'(i);
  endfunction
endpackage

// File: rtl/prio_enc_comb_4x2.sv
// Combinational 4-to-2 priority encoder: highest set index plus an any flag.
module prio_enc_comb_4x2
  import prio_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  pend,
  output logic [CODE_W-1:0] idx,
  output logic              any
);
  assign idx = highest_index(pend);
  assign any = |pend;
endmodule

// File: rtl/priority_encoder_4x2_seq.sv
// Sequential 4-to-2 priority encoder: captures requests into a pending register
// and presents the highest pending index under a valid/ack handshake.
module priority_encoder_4x2_seq
  import prio_enc_pkg::*;
#(
  parameter bit EDGE_DETECT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  input  logic              clr_ovf,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending,
  output logic              overflow
);
  enc_state_t        state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  req_q, req_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;

  logic [N_REQ-1:0]  set_cond, clr_mask;
  logic [CODE_W-1:0] cur_idx, post_idx;
  logic              cur_any, post_any, ack_fire;

  prio_enc_comb_4x2 u_enc_cur  (.pend(pending_q), .idx(cur_idx),  .any(cur_any));
  prio_enc_comb_4x2 u_enc_post (.pend(pending_d), .idx(post_idx), .any(post_any));

  always_comb begin
    req_d    = req;
    set_cond = '0;
    if (en) set_cond = EDGE_DETECT ? (req & ~req_q) : req;
    ack_fire = (state_q == PRESENT) && ack;
    clr_mask = ack_fire ? (N_REQ'(1) << code_q) : '0;
    // Sets are OR'ed after the clear, so a same-cycle set on the acked bit keeps it.
    pending_d  = (pending_q & ~clr_mask) | set_cond;
    overflow_d = (overflow_q & ~clr_ovf) | (|(set_cond & pending_q & ~clr_mask));
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (cur_any) begin
          state_d = PRESENT;
          code_d  = cur_idx;
          valid_d = 1'b1;
        end else begin
          code_d  = '0;
          valid_d = 1'b0;
        end
      end
      PRESENT: begin
        // Back-to-back reload from the post-ack pending value avoids a bubble.
        if (ack_fire) begin
          if (post_any) begin
            code_d  = post_idx;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            code_d  = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      req_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_q      <= req_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_priority_encoder_4x2_seq.sv
// Scoreboard bench: level-mode and edge-mode instances, expected codes queued
// at stimulus time and popped by per-instance monitors on each handshake.
module tb_priority_encoder_4x2_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] req = '0, req_e = '0;
  logic       ack = 1'b0, ack_e = 1'b0;
  logic [1:0] code, code_e;
  logic       valid, valid_e, overflow, overflow_e;
  logic [3:0] pending, pending_e;

  int tests = 0;
  int fails = 0;
  logic [1:0] q0[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  priority_encoder_4x2_seq #(.EDGE_DETECT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ack(ack), .clr_ovf(clr_ovf),
    .code(code), .valid(valid), .pending(pending), .overflow(overflow));

  priority_encoder_4x2_seq #(.EDGE_DETECT(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req_e), .ack(ack_e), .clr_ovf(clr_ovf),
    .code(code_e), .valid(valid_e), .pending(pending_e), .overflow(overflow_e));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // A handshake is valid && ack at the negedge preceding the consuming edge.
  always @(negedge clk) begin
    if (rst_n && valid && ack) begin
      if (q0.size() == 0) chk("mon0_unexpected_code", int'(code), -1);
      else chk("mon0_code", int'(code), int'(q0.pop_front()));
    end
    if (rst_n && valid_e && ack_e) begin
      if (q1.size() == 0) chk("mon1_unexpected_code", int'(code_e), -1);
      else chk("mon1_code", int'(code_e), int'(q1.pop_front()));
    end
  end

  initial begin
    cyc(2);
    chk("rst_valid", valid, 0);
    chk("rst_code", code, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Single request: two-cycle latency, held until ack.
    req = 4'b0100; q0.push_back(2'd2);
    cyc(); req = '0;
    chk("t1_pending", pending, 4'b0100);
    chk("t1_valid_early", valid, 0);
    cyc();
    chk("t1_valid", valid, 1);
    chk("t1_code", code, 2);
    cyc(2);
    chk("t1_code_held", code, 2);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("t1_valid_after_ack", valid, 0);

    // Back-to-back drain of 1011 with ack held high.
    req = 4'b1011; q0.push_back(2'd3); q0.push_back(2'd1); q0.push_back(2'd0);
    cyc(); req = '0; ack = 1'b1;
    cyc();
    chk("t2_first_code", code, 3);
    cyc(3); ack = 1'b0;
    chk("t2_valid_end", valid, 0);
    chk("t2_pending_end", pending, 0);

    // Higher-priority arrival does not preempt.
    req = 4'b0010; q0.push_back(2'd1); q0.push_back(2'd3);
    cyc(); req = '0;
    cyc();
    req = 4'b1000; cyc(); req = '0;
    chk("t3_no_preempt", code, 1);
    chk("t3_pending", pending, 4'b1010);
    ack = 1'b1; cyc();
    chk("t3_next_code", code, 3);
    cyc(); ack = 1'b0;
    chk("t3_valid_end", valid, 0);

    // Edge-detect instance: held request presents once, re-raise presents again.
    ack_e = 1'b1;
    req_e = 4'b0100; q1.push_back(2'd2);
    cyc(5); req_e = '0;
    cyc(2);
    req_e = 4'b0100; q1.push_back(2'd2);
    cyc(); req_e = '0;
    cyc(3); ack_e = 1'b0;
    chk("t4_valid_end", valid_e, 0);
    chk("t4_pending_end", pending_e, 0);

    // Overflow on merge, clr_ovf, and set-wins on the acked bit.
    req = 4'b0001; q0.push_back(2'd0);
    cyc(); req = '0;
    cyc();
    req = 4'b0001; cyc(); req = '0;
    chk("t5_overflow_set", overflow, 1);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    chk("t5_overflow_clr", overflow, 0);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("t5_idle", valid, 0);
    req = 4'b0010; q0.push_back(2'd1); q0.push_back(2'd1);
    cyc(); req = '0;
    cyc();
    req = 4'b0010; ack = 1'b1; cyc(); req = '0;
    chk("t5_set_wins_pending", pending, 4'b0010);
    chk("t5_set_wins_no_ovf", overflow, 0);
    chk("t5_set_wins_valid", valid, 1);
    cyc(); ack = 1'b0;
    chk("t5_pending_end", pending, 0);

    // en=0 blocks capture; async reset mid-presentation.
    req = 4'b0100; q0.push_back(2'd2);
    cyc(); req = '0;
    cyc();
    en = 1'b0; req = 4'b1111;
    cyc();
    chk("t6_en0_pending", pending, 4'b0100);
    cyc(); req = '0; en = 1'b1;
    chk("t6_en0_pending2", pending, 4'b0100);
    req = 4'b0100; cyc(); req = '0;
    chk("t6_ovf_before_rst", overflow, 1);
    chk("t6_valid_before_rst", valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_code", code, 0);
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_overflow", overflow, 0);
    q0.delete();
    cyc(); rst_n = 1'b1;
    cyc(2);
    chk("t6_post_rst_valid", valid, 0);

    chk("sb0_empty", q0.size(), 0);
    chk("sb1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/priority_encoder_4x2_seq.md
# priority_encoder_4x2_seq

Sequential 4-to-2 priority encoder, the encoding counterpart of the 2x4 decoder. It captures up to four request lines into a pending register and presents the highest-priority pending index as a 2-bit code. Each code is held under a valid/ack handshake until consumed. It sits on the producer side of any path that ends in a 2x4 decoder, such as interrupt or select lines, so the decoder's `a`/`b` inputs can be driven from `code[1]`/`code[0]`.

## Interface
- `EDGE_DETECT`, default 0. 0: a request bit sets its pending bit whenever it is high and sampled. 1: only a 0→1 transition of that bit sets it.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  capture enable. Same role as the decoder's `e`.
- `req`  in  4  request lines. Bit 3 has the highest priority, bit 0 the lowest.
- `ack`  in  1  consumer accepts the current code. Only meaningful while `valid`=1.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `code`  out  2  encoded index of the presented request.
- `valid`  out  1  `code` is valid and held.
- `pending`  out  4  current pending register, for visibility.
- `overflow`  out  1  sticky flag: a request was lost by merging into an already-pending bit.

## Operation
- Capture, registered, when `en`=1:
  - A set condition is `req[i]`, or `req[i] & ~req_q[i]` when `EDGE_DETECT`=1.
  - The set condition makes `pending[i]` 1 at the next edge.
  - `req_q` updates every cycle regardless of `en`; its reset value is 0.
  - When `en`=0, no bits are set. Pending bits are retained and presentation continues.
- Overflow: set when a set condition hits a bit that is already pending and not being cleared in the same cycle.
  - A set in the same cycle as `clr_ovf` wins, so `overflow` stays 1.
  - `overflow` stays 1 until `clr_ovf` or reset.
- FSM states are IDLE and PRESENT.
  - IDLE: if `pending`≠0, load `code` with the highest set index and set `valid`=1; go to PRESENT. Otherwise stay, with `valid`=0.
  - PRESENT: `code` and `valid` are frozen. A higher-priority request arriving here is recorded in `pending` but does not preempt.
  - PRESENT with `ack`=1: clear `pending[code]`.
    - If a same-cycle set targets that bit, the set wins, the bit stays 1, and `overflow` is not set.
    - If the post-update pending value is nonzero, load the new highest index and keep `valid`=1 (back-to-back, no bubble).
    - Otherwise return to IDLE with `valid`=0.
  - PRESENT with `ack`=0: hold.
- Priority is fixed: 3 > 2 > 1 > 0. The encoding is `code` = index.
- Reset: asynchronous assert, all outputs 0, `pending`=0, state IDLE.
  - Reset mid-presentation drops all pending requests without reporting them.

## Timing
- Request sampled at edge n → `pending` bit visible after edge n → `valid`/`code` after edge n+1. Latency is 2 cycles from sample to `valid`.
- `ack` sampled at edge m:
  - with another request pending, the new `code` is valid after edge m;
  - with nothing pending, `valid` is 0 after edge m.
- Maximum throughput is one code per cycle while `ack` is held high and requests remain.
- `code` is driven as 2'b00 whenever `valid`=0. The consumer must not decode it without `valid`.
- All outputs are registered. There is no combinational path from `req`/`ack` to any output.

## Structure
- Package `prio_enc_pkg` holds:
  - `N_REQ`=4 and `CODE_W`=2;
  - the state enum `enc_state_t` {IDLE, PRESENT};
  - a `highest_index(pending)` function.
- Sub-module `prio_enc_comb_4x2` is purely combinational. It takes `pending[3:0]` and produces the 2-bit index plus an `any` flag. It is instantiated twice: once on `pending`, once on the post-ack pending value.
- The top level holds `pending`, `req_q`, the FSM, `overflow` and the output registers.

## Test plan
- Reset, then `req`=4'b0100 for one cycle with `en`=1, `ack`=0 → `valid`=1 and `code`=2 two cycles later, held until ack. `pending`=4'b0100.
- `pending`=4'b1011 with `ack` held high → `code` sequence 3, 1, 0 on consecutive cycles, then `valid`=0 and `pending`=0.
- While presenting `code`=1, raise `req[3]` → `code` stays 1. After ack, `code`=3 on the next cycle.
- `EDGE_DETECT`=1, `req[2]` held high for 5 cycles → exactly one presentation of `code`=2. Releasing `req[2]`, then raising it again → a second presentation.
- `req[0]` pulsed twice while `pending[0]`=1 and no ack → `overflow`=1. `clr_ovf` → `overflow`=0. `req[1]` raised in the ack cycle for `code`=1 → `pending[1]` stays 1 and `overflow` stays 0.
- `en`=0 with `req`=4'b1111 → `pending` unchanged. `rst_n` low mid-PRESENT → `valid`, `code`, `pending` and `overflow` all 0 immediately (asynchronous).
